// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   word_t / instr_t : 32-bit machine word and instruction
//   fetch_state_t    : fetch FSM states (FETCH issues, WAIT awaits response)
//   redirect_src_t   : which redirect source won the priority select
//   RESET_PC         : PC loaded on reset
//   EXC_VECTOR       : PC loaded on an exception redirect
package fetch_unit_pkg;

  typedef logic [31:0] word_t;
  typedef word_t       instr_t;

  localparam word_t RESET_PC   = 32'h0000_1000;
  localparam word_t EXC_VECTOR = 32'h0000_2000;

  typedef enum logic {
    FETCH,
    WAIT
  } fetch_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EXC,
    SRC_IRET,
    SRC_BR
  } redirect_src_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational priority select of the PC redirect source.
// Priority: exception > iret > taken jump/branch. The chosen target is
// forced word aligned.
//   exc_valid              in  : exception redirect to EXC_VECTOR
//   iret_valid, iret_pc    in  : return redirect and its target
//   br_valid, br_pc        in  : taken jump/branch and its target
//   redirect_valid         out : some redirect is active this cycle
//   redirect_pc            out : aligned target of the winning source
//   redirect_src           out : winning source (SRC_NONE if none)
module fetch_pc_sel #(
  parameter int unsigned       WORD_W     = 32,
  parameter logic [WORD_W-1:0] EXC_VECTOR = fetch_unit_pkg::EXC_VECTOR
) (
  input  logic                          exc_valid,
  input  logic                          iret_valid,
  input  logic [WORD_W-1:0]             iret_pc,
  input  logic                          br_valid,
  input  logic [WORD_W-1:0]             br_pc,
  output logic                          redirect_valid,
  output logic [WORD_W-1:0]             redirect_pc,
  output fetch_unit_pkg::redirect_src_t redirect_src
);
  import fetch_unit_pkg::*;

  logic [WORD_W-1:0] target;

  always_comb begin
    redirect_src = SRC_NONE;
    target       = '0;
    if (exc_valid) begin
      redirect_src = SRC_EXC;
      target       = EXC_VECTOR;
    end else if (iret_valid) begin
      redirect_src = SRC_IRET;
      target       = iret_pc;
    end else if (br_valid) begin
      redirect_src = SRC_BR;
      target       = br_pc;
    end
    redirect_valid = (redirect_src != SRC_NONE);
    redirect_pc    = {target[WORD_W-1:2], 2'b00};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding-request
// fetches to the instruction cache and hands {instr, pc, fault} to decode
// through a valid/stall handshake. Redirects (exception, iret, branch)
// flush the output register and discard any stale in-flight response.
//   clk, rst                 : clock, asynchronous active-high reset
//   ic_req, ic_addr          out : fetch request and word-aligned address
//   ic_gnt                   in  : cache accepted the request this cycle
//   ic_rvalid/rdata/rerr     in  : response valid, instruction, fault flag
//   exc_valid                in  : exception redirect to EXC_VECTOR
//   iret_valid, iret_pc      in  : return redirect
//   br_valid, br_pc          in  : taken jump/branch redirect
//   dec_stall                in  : decoder cannot accept this cycle
//   if_valid/instr/pc/fault  out : output register towards the decoder
module fetch_unit #(
  parameter int unsigned       WORD_W     = 32,
  parameter logic [WORD_W-1:0] RESET_PC   = fetch_unit_pkg::RESET_PC,
  parameter logic [WORD_W-1:0] EXC_VECTOR = fetch_unit_pkg::EXC_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ic_req,
  output logic [WORD_W-1:0] ic_addr,
  input  logic              ic_gnt,
  input  logic              ic_rvalid,
  input  logic [WORD_W-1:0] ic_rdata,
  input  logic              ic_rerr,
  input  logic              exc_valid,
  input  logic              iret_valid,
  input  logic [WORD_W-1:0] iret_pc,
  input  logic              br_valid,
  input  logic [WORD_W-1:0] br_pc,
  input  logic              dec_stall,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic              if_fault
);
  import fetch_unit_pkg::*;

  fetch_state_t      state, state_d;
  logic [WORD_W-1:0] pc, pc_d;
  logic              drop, drop_d;
  logic              if_valid_d, if_fault_d;
  logic [WORD_W-1:0] if_instr_d, if_pc_d;

  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  redirect_src_t     redirect_src;
  logic              redirect;
  logic              grant, consume, in_flight;

  fetch_pc_sel #(
    .WORD_W     (WORD_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_sel (
    .exc_valid      (exc_valid),
    .iret_valid     (iret_valid),
    .iret_pc        (iret_pc),
    .br_valid       (br_valid),
    .br_pc          (br_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_src   (redirect_src)
  );

  assign redirect = redirect_valid && (redirect_src != SRC_NONE);

  // Request only when the output register will be free at the next edge.
  assign ic_req    = !rst && (state == FETCH) && (!if_valid || !dec_stall);
  assign ic_addr   = pc;
  assign grant     = ic_req && ic_gnt;
  assign consume   = if_valid && !dec_stall;
  assign in_flight = ((state == WAIT) && !ic_rvalid) || grant;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    drop_d     = drop;
    if_valid_d = if_valid && !consume;
    if_instr_d = if_instr;
    if_pc_d    = if_pc;
    if_fault_d = if_fault;
    if (redirect) begin
      // A redirect beats any response landing this cycle; if a response
      // is still owed, wait for it and throw it away.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if (in_flight) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = FETCH;
        drop_d  = 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (grant) state_d = WAIT;
        end
        WAIT: begin
          if (ic_rvalid) begin
            state_d = FETCH;
            if (drop) begin
              drop_d = 1'b0;
            end else begin
              if_valid_d = 1'b1;
              if_instr_d = ic_rerr ? '0 : ic_rdata;
              if_pc_d    = pc;
              if_fault_d = ic_rerr;
              pc_d       = pc + WORD_W'(4);
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      if_fault <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      drop     <= drop_d;
      if_valid <= if_valid_d;
      if_instr <= if_instr_d;
      if_pc    <= if_pc_d;
      if_fault <= if_fault_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: the producer side of the decode stage's instruction interface.
- Owns the PC and issues one-outstanding-request fetches to the instruction cache.
- Presents {instr, pc, fault} to the decoder through a valid/stall handshake.
- Applies redirects from exceptions, iret, and taken jump/branch, discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_1000, PC loaded on reset
- EXC_VECTOR, 32'h0000_2000, PC loaded on exception redirect
- WORD_W, 32, PC, address and instruction width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ic_req  out  1  fetch request valid
- ic_addr  out  WORD_W  fetch address, word aligned
- ic_gnt  in  1  cache accepted request this cycle
- ic_rvalid  in  1  response valid
- ic_rdata  in  WORD_W  fetched instruction
- ic_rerr  in  1  response is a fault (iTLB miss/bus error), qualified by ic_rvalid
- exc_valid  in  1  exception redirect to EXC_VECTOR
- iret_valid  in  1  return redirect to iret_pc
- iret_pc  in  WORD_W  saved PC
- br_valid  in  1  taken jump/branch redirect
- br_pc  in  WORD_W  jump/branch target
- dec_stall  in  1  decoder cannot accept this cycle
- if_valid  out  1  output register holds an instruction
- if_instr  out  WORD_W  instruction (common::instr_t)
- if_pc  out  WORD_W  PC of if_instr
- if_fault  out  1  fetch faulted; if_instr is 0

Behaviour:
- Reset values:
  - state=FETCH, pc=RESET_PC, drop=0.
  - if_valid=0, if_instr=0, if_pc=0, if_fault=0.
  - ic_req is forced 0 while rst is high.
- States:
  - FETCH: ic_req=1 iff output register free (!if_valid, or if_valid && !dec_stall); ic_addr=pc. ic_req && ic_gnt -> WAIT.
  - WAIT: ic_req=0. On ic_rvalid:
    - if drop: discard the response, clear drop, -> FETCH.
    - else: if_valid<=1, if_instr<=ic_rerr?0:ic_rdata, if_pc<=pc, if_fault<=ic_rerr, pc<=pc+4 (mod 2^32), -> FETCH.
- Issue: never issue a request in the response cycle. Peak throughput is 1 instruction per 2 cycles with a 1-cycle cache.
- Handshake: the decoder consumes when if_valid && !dec_stall. On consume with no new load, if_valid<=0. While if_valid && dec_stall, all if_* outputs are held stable.
- Latency: request granted at cycle t, rvalid at t+1, if_valid at t+2.
- Redirect priority, for simultaneous assertions: exc_valid > iret_valid > br_valid. The selected target has bits [1:0] cleared.
- On any redirect, at the same edge:
  - pc<=target; if_valid<=0 (flush).
  - state<=FETCH unless a request is in flight.
  - In flight means: state WAIT without ic_rvalid this cycle, or ic_req && ic_gnt this cycle. In that case state becomes/stays WAIT and drop<=1.
  - If a redirect coincides with ic_rvalid, the response is discarded, pc takes the target, and no increment occurs.
- Redirect while dec_stall: the flush wins; the held instruction is lost.
- Repeated redirects while drop=1: the last target wins; still exactly one response is dropped.
- Fault: a faulted word is delivered like a normal one. Fetch continues sequentially; the exception redirect is the consumer's job.
- Async reset mid-WAIT: state returns to FETCH. The late ic_rvalid arrives in FETCH and must be ignored (responses are only accepted in WAIT).

Decomposition:
- Package common gets:
  - fetch_state_t enum {FETCH, WAIT}
  - redirect_src_t enum {none, exc, iret, br}
  - constants RESET_PC and EXC_VECTOR
  - reuse of common::instr_t and word_t
- Sub-module fetch_pc_sel: combinational priority select of the redirect source. Outputs redirect_valid, redirect_pc (aligned) and redirect_src_t.

Test Plan:
1. Reset release, 1-cycle cache, ic_gnt=1, dec_stall=0 -> ic_addr 0x1000, 0x1004, 0x1008 every 2 cycles; if_pc follows 2 cycles after each grant; if_instr equals ic_rdata.
2. dec_stall=1 for 5 cycles with if_valid=1 (pc 0x1004) -> if_* stable, ic_req=0; after release the decoder receives 0x1004 exactly once, then the fetch of 0x1008 is issued.
3. br_valid with br_pc=0x1043 one cycle after grant of 0x1008 -> 0x1008 response dropped; next ic_addr=0x1040; if_valid cleared at the redirect edge.
4. exc_valid, iret_valid(0x3000) and br_valid(0x4000) in the same cycle -> next ic_addr=0x2000; the same cycle with only iret and br -> 0x3000.
5. Response with ic_rerr=1 at pc 0x1010 -> if_fault=1, if_instr=0, if_pc=0x1010; next fetch is 0x1014.
6. rst pulsed while in WAIT, then a stray ic_rvalid -> no if_valid; the first request after release is 0x1000.
